// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave front end: turns AW/W and AR requests into single
// request packets toward the cache FIFO and returns B and R responses.
//
// Ports:
//   aclk_i, arst_i            clock, async active-high reset
//   aw*/w*/b*                 AXI4-Lite write channels (bresp always OKAY)
//   ar*/r*                    AXI4-Lite read channels (rresp always OKAY)
//   data_pkt_o, valid_pkt_o,
//   ready_pkt_i               request packet {we, addr, data, strb}
//   cache_data_i,
//   cache_valid_i, cpu_ready_o  read data returned from the cache
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DATA_BYTES = DATA_WIDTH / 8,
  parameter int FIFO_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH + DATA_BYTES
) (
  input  logic                  aclk_i,
  input  logic                  arst_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic [2:0]            awprot_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_BYTES-1:0] wstrb_i,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic [1:0]            bresp_o,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic [2:0]            arprot_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [1:0]            rresp_o,
  output logic [FIFO_WIDTH-1:0] data_pkt_o,
  output logic                  valid_pkt_o,
  input  logic                  ready_pkt_i,
  input  logic [DATA_WIDTH-1:0] cache_data_i,
  input  logic                  cache_valid_i,
  output logic                  cpu_ready_o
);

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [DATA_BYTES-1:0] w_strb;
  logic                  ar_full;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic                  rd_busy;
  logic                  pkt_valid;
  logic [FIFO_WIDTH-1:0] pkt_data;
  logic                  bvalid;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic pkt_hs;
  logic pkt_is_wr;
  logic wr_issue;
  logic rd_issue;

  logic unused_prot;
  assign unused_prot = ^{awprot_i, arprot_i};

  assign awready_o   = !aw_full;
  assign wready_o    = !w_full;
  // A read is in flight from AR capture until the R beat is taken.
  assign arready_o   = !ar_full && !rd_busy && !rvalid;
  assign cpu_ready_o = !rvalid;
  assign bvalid_o    = bvalid;
  assign rvalid_o    = rvalid;
  assign rdata_o     = rdata;
  assign bresp_o     = 2'b00;
  assign rresp_o     = 2'b00;
  assign valid_pkt_o = pkt_valid;
  assign data_pkt_o  = pkt_data;

  assign aw_hs     = awvalid_i && !aw_full;
  assign w_hs      = wvalid_i && !w_full;
  assign ar_hs     = arvalid_i && arready_o;
  assign pkt_hs    = pkt_valid && ready_pkt_i;
  assign pkt_is_wr = pkt_data[FIFO_WIDTH-1];

  // Buffers stay full until their packet is taken, which
  // is what stalls a second AW/W behind a pending write.
  assign wr_issue = aw_full && w_full && !pkt_valid && !bvalid;
  assign rd_issue = ar_full && !pkt_valid && !wr_issue;

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
    end else if (pkt_hs && pkt_is_wr) begin
      aw_full <= 1'b0;
    end else if (aw_hs) begin
      aw_full <= 1'b1;
      aw_addr <= awaddr_i;
    end
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      w_full <= 1'b0;
      w_data <= '0;
      w_strb <= '0;
    end else if (pkt_hs && pkt_is_wr) begin
      w_full <= 1'b0;
    end else if (w_hs) begin
      w_full <= 1'b1;
      w_data <= wdata_i;
      w_strb <= wstrb_i;
    end
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      ar_full <= 1'b0;
      ar_addr <= '0;
    end else if (pkt_hs && !pkt_is_wr) begin
      ar_full <= 1'b0;
    end else if (ar_hs) begin
      ar_full <= 1'b1;
      ar_addr <= araddr_i;
    end
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
    end else if (wr_issue) begin
      pkt_valid <= 1'b1;
      pkt_data  <= {1'b1, aw_addr, w_data, w_strb};
    end else if (rd_issue) begin
      pkt_valid <= 1'b1;
      pkt_data  <= {1'b0, ar_addr,
                    {(DATA_WIDTH + DATA_BYTES){1'b0}}};
    end else if (pkt_hs) begin
      pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      bvalid <= 1'b0;
    end else if (pkt_hs && pkt_is_wr) begin
      bvalid <= 1'b1;
    end else if (bready_i) begin
      bvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      rd_busy <= 1'b0;
    end else if (pkt_hs && !pkt_is_wr) begin
      rd_busy <= 1'b1;
    end else if (rvalid && rready_i) begin
      rd_busy <= 1'b0;
    end
  end

  // Cache data is forwarded even with no read outstanding.
  always_ff @(posedge aclk_i or posedge arst_i) begin
    if (arst_i) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (cache_valid_i && !rvalid) begin
      rvalid <= 1'b1;
      rdata  <= cache_data_i;
    end else if (rvalid && rready_i) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Self-checking bench for axi4_lite_slave using packet and read-data
// scoreboards filled at stimulus time and drained on DUT output.
module tb_axi4_lite_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DB = DW / 8;
  localparam int FW = 1 + AW + DW + DB;

  logic          aclk = 1'b0;
  logic          arst;
  logic          awvalid;
  logic          awready;
  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic [DB-1:0] wstrb;
  logic          bvalid;
  logic          bready;
  logic [1:0]    bresp;
  logic          arvalid;
  logic          arready;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic [FW-1:0] data_pkt;
  logic          valid_pkt;
  logic          ready_pkt;
  logic [DW-1:0] cache_data;
  logic          cache_valid;
  logic          cpu_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [FW-1:0] exp_pkt_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [FW-1:0] exp_pkt;
  logic [DW-1:0] exp_rd;

  always #5 aclk = ~aclk;

  axi4_lite_slave dut (
    .aclk_i       (aclk),
    .arst_i       (arst),
    .awvalid_i    (awvalid),
    .awready_o    (awready),
    .awaddr_i     (awaddr),
    .awprot_i     (awprot),
    .wvalid_i     (wvalid),
    .wready_o     (wready),
    .wdata_i      (wdata),
    .wstrb_i      (wstrb),
    .bvalid_o     (bvalid),
    .bready_i     (bready),
    .bresp_o      (bresp),
    .arvalid_i    (arvalid),
    .arready_o    (arready),
    .araddr_i     (araddr),
    .arprot_i     (arprot),
    .rvalid_o     (rvalid),
    .rready_i     (rready),
    .rdata_o      (rdata),
    .rresp_o      (rresp),
    .data_pkt_o   (data_pkt),
    .valid_pkt_o  (valid_pkt),
    .ready_pkt_i  (ready_pkt),
    .cache_data_i (cache_data),
    .cache_valid_i(cache_valid),
    .cpu_ready_o  (cpu_ready)
  );

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic idle_inputs();
    awvalid     = 1'b0;
    awaddr      = '0;
    awprot      = 3'b0;
    wvalid      = 1'b0;
    wdata       = '0;
    wstrb       = '0;
    bready      = 1'b1;
    arvalid     = 1'b0;
    araddr      = '0;
    arprot      = 3'b0;
    rready      = 1'b0;
    ready_pkt   = 1'b1;
    cache_data  = '0;
    cache_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    arst = 1'b1;
    repeat (5) tick();
    n_checks++;
    if ({awready, wready, arready, cpu_ready,
         bvalid, rvalid, valid_pkt} !== 7'b1111000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 1111000",
               {awready, wready, arready, cpu_ready,
                bvalid, rvalid, valid_pkt});
    end
    n_checks++;
    if (data_pkt !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL reset_data: pkt %h rdata %h expected 0",
               data_pkt, rdata);
    end
    n_checks++;
    if ({bresp, rresp} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_resp: got %b expected 0000",
               {bresp, rresp});
    end
    arst = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (valid_pkt !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_pkt: valid %b expected 0", valid_pkt);
    end
  endtask

  task automatic test_seq_write();
    int cyc;
    for (int i = 1; i <= 4; i++) begin
      awvalid = 1'b1;
      awaddr  = '0;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b1;
      wdata   = DW'(i);
      wstrb   = 4'hF;
      exp_pkt_q.push_back({1'b1, 32'd0, DW'(i), 4'hF});
      tick();
      wvalid = 1'b0;
      cyc = 0;
      while (!valid_pkt && cyc < 20) begin
        tick();
        cyc++;
      end
      n_checks++;
      if (cyc !== 1) begin
        n_fail++;
        $display("FAIL seq_wr_latency[%0d]: %0d cycles expected 1",
                 i, cyc);
      end
      exp_pkt = exp_pkt_q.pop_front();
      n_checks++;
      if (data_pkt !== exp_pkt) begin
        n_fail++;
        $display("FAIL seq_wr_pkt[%0d]: got %h expected %h",
                 i, data_pkt, exp_pkt);
      end
      tick();
      n_checks++;
      if ({bvalid, bresp, valid_pkt, awready, wready}
          !== 6'b1_00_0_11) begin
        n_fail++;
        $display("FAIL seq_wr_b[%0d]: got %b expected 100011",
                 i, {bvalid, bresp, valid_pkt, awready, wready});
      end
      tick();
      n_checks++;
      if ({bvalid, valid_pkt} !== 2'b00) begin
        n_fail++;
        $display("FAIL seq_wr_b_clear[%0d]: got %b expected 00",
                 i, {bvalid, valid_pkt});
      end
    end
  endtask

  task automatic test_simul_write();
    awvalid = 1'b1;
    awaddr  = 32'd1;
    wvalid  = 1'b1;
    wdata   = 32'd5;
    wstrb   = 4'hF;
    exp_pkt_q.push_back({1'b1, 32'd1, 32'd5, 4'hF});
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n_checks++;
    if ({awready, wready, valid_pkt} !== 3'b000) begin
      n_fail++;
      $display("FAIL simul_accept: got %b expected 000",
               {awready, wready, valid_pkt});
    end
    tick();
    exp_pkt = exp_pkt_q.pop_front();
    n_checks++;
    if (valid_pkt !== 1'b1 || data_pkt !== exp_pkt) begin
      n_fail++;
      $display("FAIL simul_pkt: valid %b pkt %h expected 1 %h",
               valid_pkt, data_pkt, exp_pkt);
    end
    tick();
    n_checks++;
    if (bvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_b: got %b expected 1", bvalid);
    end
    tick();
  endtask

  task automatic test_read();
    arvalid = 1'b1;
    araddr  = 32'd5;
    exp_pkt_q.push_back({1'b0, 32'd5, 32'd0, 4'h0});
    tick();
    arvalid = 1'b0;
    n_checks++;
    if (arready !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_arready_low: got %b expected 0", arready);
    end
    tick();
    exp_pkt = exp_pkt_q.pop_front();
    n_checks++;
    if (valid_pkt !== 1'b1 || data_pkt !== exp_pkt) begin
      n_fail++;
      $display("FAIL rd_pkt: valid %b pkt %h expected 1 %h",
               valid_pkt, data_pkt, exp_pkt);
    end
    tick();
    n_checks++;
    if ({valid_pkt, arready, bvalid} !== 3'b000) begin
      n_fail++;
      $display("FAIL rd_outstanding: got %b expected 000",
               {valid_pkt, arready, bvalid});
    end
    rready      = 1'b0;
    cache_valid = 1'b1;
    cache_data  = 32'd2;
    exp_rd_q.push_back(32'd2);
    tick();
    cache_valid = 1'b0;
    cache_data  = 32'd77;
    tick();
    exp_rd = exp_rd_q.pop_front();
    n_checks++;
    if ({rvalid, cpu_ready, rresp} !== 4'b1000 || rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL rd_data_hold: rv/cr/rr %b rdata %h expected 1000 %h",
               {rvalid, cpu_ready, rresp}, rdata, exp_rd);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_checks++;
    if ({rvalid, arready, cpu_ready} !== 3'b011) begin
      n_fail++;
      $display("FAIL rd_done: got %b expected 011",
               {rvalid, arready, cpu_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] held;
    ready_pkt = 1'b0;
    awvalid   = 1'b1;
    awaddr    = 32'h0000_0040;
    wvalid    = 1'b1;
    wdata     = 32'hA5A5_5A5A;
    wstrb     = 4'h3;
    exp_pkt_q.push_back({1'b1, 32'h40, 32'hA5A5_5A5A, 4'h3});
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    tick();
    held = data_pkt;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({valid_pkt, bvalid, awready, wready} !== 4'b1000 ||
          data_pkt !== held) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: flags %b pkt %h expected 1000 %h",
                 c, {valid_pkt, bvalid, awready, wready}, data_pkt, held);
      end
      tick();
    end
    exp_pkt = exp_pkt_q.pop_front();
    n_checks++;
    if (data_pkt !== exp_pkt) begin
      n_fail++;
      $display("FAIL bp_pkt: got %h expected %h", data_pkt, exp_pkt);
    end
    ready_pkt = 1'b1;
    tick();
    n_checks++;
    if ({valid_pkt, bvalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_release: got %b expected 01",
               {valid_pkt, bvalid});
    end
    tick();
    n_checks++;
    if ({valid_pkt, bvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL bp_single: got %b expected 00",
               {valid_pkt, bvalid});
    end
  endtask

  task automatic test_arbitration();
    int cyc;
    awvalid = 1'b1;
    awaddr  = 32'h100;
    wvalid  = 1'b1;
    wdata   = 32'h1234_5678;
    wstrb   = 4'hC;
    arvalid = 1'b1;
    araddr  = 32'h200;
    exp_pkt_q.push_back({1'b1, 32'h100, 32'h1234_5678, 4'hC});
    exp_pkt_q.push_back({1'b0, 32'h200, 32'd0, 4'h0});
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    arvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc = 0;
      while (!valid_pkt && cyc < 20) begin
        tick();
        cyc++;
      end
      exp_pkt = exp_pkt_q.pop_front();
      n_checks++;
      if (valid_pkt !== 1'b1 || data_pkt !== exp_pkt) begin
        n_fail++;
        $display("FAIL arb_order[%0d]: valid %b pkt %h expected 1 %h",
                 k, valid_pkt, data_pkt, exp_pkt);
      end
      tick();
    end
    cache_valid = 1'b1;
    cache_data  = 32'h33;
    exp_rd_q.push_back(32'h33);
    tick();
    cache_valid = 1'b0;
    exp_rd = exp_rd_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_rd) begin
      n_fail++;
      $display("FAIL arb_rdata: rvalid %b rdata %h expected 1 %h",
               rvalid, rdata, exp_rd);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_checks++;
    if ({rvalid, arready} !== 2'b01) begin
      n_fail++;
      $display("FAIL arb_rd_done: got %b expected 01", {rvalid, arready});
    end
  endtask

  task automatic test_unsolicited();
    cache_valid = 1'b1;
    cache_data  = 32'hDEAD_BEEF;
    exp_rd_q.push_back(32'hDEAD_BEEF);
    tick();
    cache_valid = 1'b0;
    exp_rd = exp_rd_q.pop_front();
    n_checks++;
    if (rvalid !== 1'b1 || rdata !== exp_rd || arready !== 1'b0) begin
      n_fail++;
      $display("FAIL unsol_r: rv %b rdata %h ar %b expected 1 %h 0",
               rvalid, rdata, arready, exp_rd);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_mid_reset();
    ready_pkt = 1'b0;
    awvalid   = 1'b1;
    awaddr    = 32'h44;
    wvalid    = 1'b1;
    wdata     = 32'h99;
    wstrb     = 4'hF;
    tick();
    awvalid     = 1'b0;
    wvalid      = 1'b0;
    cache_valid = 1'b1;
    cache_data  = 32'h9;
    tick();
    cache_valid = 1'b0;
    n_checks++;
    if ({valid_pkt, rvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL mr_setup: got %b expected 11", {valid_pkt, rvalid});
    end
    #2;
    arst = 1'b1;
    #1;
    n_checks++;
    if ({awready, wready, arready, cpu_ready,
         bvalid, rvalid, valid_pkt} !== 7'b1111000 ||
        data_pkt !== '0 || rdata !== '0) begin
      n_fail++;
      $display("FAIL mr_async: flags %b pkt %h rdata %h expected 1111000 0 0",
               {awready, wready, arready, cpu_ready,
                bvalid, rvalid, valid_pkt}, data_pkt, rdata);
    end
    #1;
    arst      = 1'b0;
    ready_pkt = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({valid_pkt, bvalid, awready} !== 3'b001) begin
      n_fail++;
      $display("FAIL mr_dropped: got %b expected 001",
               {valid_pkt, bvalid, awready});
    end
  endtask

  initial begin
    arst = 1'b1;
    idle_inputs();
    test_reset();
    test_seq_write();
    test_simul_write();
    test_read();
    test_backpressure();
    test_arbitration();
    test_unsolicited();
    test_mid_reset();
    n_checks++;
    if (exp_pkt_q.size() !== 0 || exp_rd_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pkts %0d reads left expected 0",
               exp_pkt_q.size(), exp_rd_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
